// File: rtl/ff_pkg.sv
// ff_pkg: shared definitions for the forward-forward datapath blocks.
//   DATA_WIDTH / FRAC_BITS : Q16.16 word format.
//   Q_ONE / Q_MAX          : 1.0 and the largest positive Q16.16 value.
//   state_t                : goodness accumulator sequencing states.
//   q_square_sat           : signed Q-format square, saturated to Q_MAX.
package ff_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;

  localparam logic [DATA_WIDTH-1:0] Q_ONE = 32'h0001_0000;
  localparam logic [DATA_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Square of a signed Q word. The full product is formed at double width,
  // so it is exact; a square is never negative, so only the upper bound
  // needs clamping.
  function automatic logic [DATA_WIDTH-1:0] q_square_sat(
    input logic signed [DATA_WIDTH-1:0] a,
    input int unsigned                  frac
  );
    logic signed [2*DATA_WIDTH-1:0] a_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;
    a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    prod  = a_ext * a_ext;
    prod  = prod >>> frac;
    if (prod > $signed({{DATA_WIDTH{1'b0}}, Q_MAX})) begin
      return Q_MAX;
    end
    return prod[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/q16_square_sat.sv
// q16_square_sat: registered saturating square, one cycle of latency.
//   clk, rst : clock, synchronous active-high reset (valid only).
//   vld_in   : a_in carries a sample this cycle.
//   a_in     : signed Q16.16 operand.
//   vld_out  : sq_out carries a result this cycle.
//   sq_out   : (a_in*a_in)>>>FRAC, clamped to Q_MAX; never negative.
module q16_square_sat
  import ff_pkg::*;
#(
  parameter int FRAC = 16
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  output logic                         vld_out,
  output logic        [DATA_WIDTH-1:0] sq_out
);

  logic                  vld_p2_d, vld_p2_q;
  logic [DATA_WIDTH-1:0] sq_p2_d,  sq_p2_q;

  always_comb begin
    vld_p2_d = vld_in;
    sq_p2_d  = sq_p2_q;
    if (vld_in) begin
      sq_p2_d = q_square_sat(a_in, FRAC);
    end
  end

  // stage 2 boundary: squared sample
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    sq_p2_q <= sq_p2_d;
  end

  assign vld_out = vld_p2_q;
  assign sq_out  = sq_p2_q;

endmodule

// File: rtl/goodness_accumulator.sv
// goodness_accumulator: streams N activations out of the activation buffer
// and accumulates sum(y_i^2) in Q16.16, reporting a saturated scalar.
//   clk, rst        : clock, synchronous active-high reset.
//   start           : one-cycle pulse, accepted only while idle.
//   active_neurons  : neuron count N, clamped to NUM_NEURONS at start.
//   act_rd_en       : buffer read strobe, one address per cycle.
//   act_addr        : buffer read address; holds when act_rd_en is low.
//   act_rdata       : buffer data, one cycle after act_rd_en.
//   goodness_out    : saturated Q16.16 goodness of the last pass.
//   goodness_valid  : goodness_out belongs to a completed pass.
//   busy            : a pass is in progress.
//   done            : one-cycle completion pulse.
module goodness_accumulator
  import ff_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int ACC_WIDTH   = 48
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(NUM_NEURONS):0]      active_neurons,
  output logic                              act_rd_en,
  output logic [$clog2(NUM_NEURONS)-1:0]    act_addr,
  input  logic signed [DATA_WIDTH-1:0]      act_rdata,
  output logic [DATA_WIDTH-1:0]             goodness_out,
  output logic                              goodness_valid,
  output logic                              busy,
  output logic                              done
);

  localparam int ADDR_W = $clog2(NUM_NEURONS);
  // One extra bit so idx can reach NUM_NEURONS without wrapping.
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NUM_NEURONS);

  function automatic logic [ACC_WIDTH-1:0] acc_add_sat(
    input logic [ACC_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, b};
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] goodness_sat(
    input logic [ACC_WIDTH-1:0] a
  );
    return (|a[ACC_WIDTH-1:DATA_WIDTH-1]) ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                          : {1'b0, a[DATA_WIDTH-2:0]};
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        n_eff_q, n_eff_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [1:0]              drain_q, drain_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   gout_q, gout_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    vld_p0_q, vld_p0_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [DATA_WIDTH-1:0] act_p1_q, act_p1_d;
  logic                    vld_p2;
  logic [DATA_WIDTH-1:0]   sq_p2;
  logic [CNT_W-1:0]        n_clamp;
  logic                    start_ok;

  assign n_clamp  = (active_neurons > N_MAX) ? N_MAX : active_neurons;
  assign start_ok = (state_q == S_IDLE) && start;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (n_clamp == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (idx_q == n_eff_q) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == 2'd2) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter and registered-output logic. idx runs one ahead of the address
  // on the bus, so FETCH ends on the cycle that issues address N_eff-1.
  always_comb begin
    n_eff_d = n_eff_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    gout_d  = gout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_eff_d = n_clamp;
          valid_d = 1'b0;
          drain_d = 2'd0;
          idx_d   = '0;
          if (n_clamp != '0) begin
            rd_en_d = 1'b1;
            addr_d  = '0;
            idx_d   = CNT_W'(1);
          end else begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            gout_d  = '0;
          end
        end
      end
      S_FETCH: begin
        if (idx_q != n_eff_q) begin
          rd_en_d = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          idx_d   = idx_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          // The final accumulate lands on this same edge, so report acc_d.
          drain_d = 2'd0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          gout_d  = goodness_sat(acc_d);
        end
      end
      default: ;
    endcase
  end

  // Pipeline datapath: read-latency valid, captured sample, accumulate.
  always_comb begin
    vld_p0_d = rd_en_q;
    vld_p1_d = vld_p0_q;
    act_p1_d = vld_p0_q ? act_rdata : act_p1_q;
    acc_d    = acc_q;
    if (start_ok) begin
      acc_d = '0;
    end else if (vld_p2) begin
      acc_d = acc_add_sat(acc_q, sq_p2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_eff_q  <= '0;
      idx_q    <= '0;
      drain_q  <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      gout_q   <= '0;
      acc_q    <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_eff_q  <= n_eff_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      gout_q   <= gout_d;
      // stage 3 boundary: accumulator
      acc_q    <= acc_d;
      // stage 0 boundary: buffer data valid on act_rdata
      vld_p0_q <= vld_p0_d;
      // stage 1 boundary: captured activation
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    act_p1_q <= act_p1_d;
  end

  q16_square_sat #(
    .FRAC (FRAC_BITS)
  ) u_square (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_p1_q),
    .a_in    (act_p1_q),
    .vld_out (vld_p2),
    .sq_out  (sq_p2)
  );

  assign act_rd_en      = rd_en_q;
  assign act_addr       = addr_q;
  assign goodness_out   = gout_q;
  assign goodness_valid = valid_q;
  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_goodness_accumulator.sv
// tb_goodness_accumulator: scoreboard bench for goodness_accumulator with a
// one-cycle-latency activation buffer model.
module tb_goodness_accumulator;
  import ff_pkg::*;

  localparam int NN = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  active_neurons = '0;
  logic        act_rd_en;
  logic [7:0]  act_addr;
  logic [31:0] act_rdata = '0;
  logic [31:0] goodness_out;
  logic        goodness_valid;
  logic        busy;
  logic        done;

  goodness_accumulator #(
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (32),
    .FRAC_BITS   (16),
    .ACC_WIDTH   (48)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .active_neurons (active_neurons),
    .act_rd_en      (act_rd_en),
    .act_addr       (act_addr),
    .act_rdata      (act_rdata),
    .goodness_out   (goodness_out),
    .goodness_valid (goodness_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NN];
  always @(posedge clk) if (act_rd_en) act_rdata <= mem[act_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  logic [31:0] sb [$];
  int rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int rd_addr [$];
  int rd_cyc [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (act_rd_en) begin
      rd_cnt++;
      rd_addr.push_back(int'(act_addr));
      rd_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("done_valid", 64'(goodness_valid), 64'd1);
      check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check_eq("goodness", 64'(goodness_out), 64'(sb.pop_front()));
    end
  end

  function automatic logic [31:0] model_goodness(input int n);
    longint acc, a, s;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      a = longint'(signed'(mem[i]));
      s = (a * a) >>> 16;
      if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
      acc = acc + s;
      if (acc > 64'sh0000_FFFF_FFFF_FFFF) acc = 64'sh0000_FFFF_FFFF_FFFF;
    end
    return (acc > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : acc[31:0];
  endfunction

  task automatic run_pass(input int n, input int n_eff, input logic [31:0] exp_g,
                          input string tag, input int restart_at, input bit start_in_done);
    int t0, dn0, rd0, k, bad;
    dn0 = done_cnt;
    rd0 = rd_cnt;
    rd_addr.delete();
    rd_cyc.delete();
    sb.push_back(exp_g);
    @(negedge clk);
    active_neurons = 9'(n);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (n_eff > 0) begin
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      check_eq({tag, "_valid_drop"}, 64'(goodness_valid), 64'd0);
    end
    if (restart_at > 0) begin
      repeat (restart_at - 1) @(negedge clk);
      active_neurons = 9'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (start_in_done) begin
      while (cyc < t0 + n_eff + 4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (done_cnt == dn0 && k < 600) begin
      @(posedge clk);
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt != dn0), 64'd1);
    repeat (8) @(negedge clk);
    check_eq({tag, "_latency"}, 64'(done_cyc - t0), 64'((n_eff == 0) ? 1 : n_eff + 4));
    check_eq({tag, "_done_count"}, 64'(done_cnt - dn0), 64'd1);
    check_eq({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(n_eff));
    bad = 0;
    foreach (rd_addr[i]) if (rd_addr[i] != i || rd_cyc[i] != t0 + 1 + i) bad++;
    check_eq({tag, "_addr_seq"}, 64'(bad), 64'd0);
    check_eq({tag, "_valid_hold"}, 64'(goodness_valid), 64'd1);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    if (n_eff > 0) check_eq({tag, "_addr_hold"}, 64'(act_addr), 64'(n_eff - 1));
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int t0, dn0;
    for (int i = 0; i < NN; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd_en", 64'(act_rd_en), 64'd0);
    check_eq("rst_addr", 64'(act_addr), 64'd0);
    check_eq("rst_gout", 64'(goodness_out), 64'd0);
    check_eq("rst_valid", 64'(goodness_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1.0, 2.0, 0.5, -1.0 -> 6.25
    mem[0] = Q_ONE; mem[1] = 32'h0002_0000; mem[2] = 32'h0000_8000; mem[3] = 32'hFFFF_0000;
    run_pass(4, 4, 32'h0006_4000, "n4", 0, 1'b0);

    for (int i = 0; i < NN; i++) mem[i] = 32'h0010_0000;
    run_pass(256, 256, 32'h7FFF_FFFF, "n256_sat", 0, 1'b0);

    mem[0] = 32'h7FFF_FFFF;
    run_pass(1, 1, 32'h7FFF_FFFF, "n1_max", 0, 1'b0);
    mem[0] = 32'h0000_0000;
    run_pass(1, 1, 32'h0000_0000, "n1_zero", 0, 1'b0);
    mem[0] = 32'h8000_0000;
    run_pass(1, 1, 32'h7FFF_FFFF, "n1_minneg", 0, 1'b0);

    run_pass(0, 0, 32'h0000_0000, "n0", 0, 1'b0);

    for (int i = 0; i < NN; i++) mem[i] = Q_ONE;
    run_pass(300, 256, 32'h0100_0000, "clamp300", 0, 1'b0);

    // Reset in the third FETCH cycle aborts the pass.
    dn0 = done_cnt;
    @(negedge clk);
    active_neurons = 9'd8;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_in_fetch", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_rd_en", 64'(act_rd_en), 64'd0);
    check_eq("abort_gout", 64'(goodness_out), 64'd0);
    check_eq("abort_valid", 64'(goodness_valid), 64'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt - dn0), 64'd0);
    check_eq("abort_cycle", 64'(cyc - t0), 64'd19);

    run_pass(2, 2, 32'h0002_0000, "after_rst", 0, 1'b0);

    for (int i = 0; i < 8; i++) mem[i] = Q_ONE * (i + 1);
    run_pass(8, 8, model_goodness(8), "restart_ignored", 2, 1'b0);

    mem[0] = 32'h0003_0000; mem[1] = 32'hFFFE_0000;
    run_pass(2, 2, 32'h000D_0000, "start_in_done", 0, 1'b1);

    for (int i = 0; i < 6; i++) mem[i] = $urandom() & 32'h800F_FFFF;
    run_pass(6, 6, model_goodness(6), "random6", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/goodness_accumulator.md
Name: goodness_accumulator

Overview:
Sequential goodness stage directly upstream of the plasticity engine. It computes goodness = sum of y_i^2 in Q16.16 over the active output neurons of a layer. It streams activations out of the activation buffer through a one-cycle-latency read port. The saturated scalar it produces drives the plasticity engine's goodness_in and also feeds the inference comparator.

Parameters:
NUM_NEURONS, 256, maximum neurons per layer (buffer depth).
DATA_WIDTH, 32, activation and goodness word width (Q16.16 signed).
FRAC_BITS, 16, fractional bits.
ACC_WIDTH, 48, internal accumulator width, unsigned.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; sampled only in IDLE.
active_neurons  in  $clog2(NUM_NEURONS)+1  neuron count N; sampled at start.
act_rd_en  out  1  activation buffer read enable.
act_addr  out  $clog2(NUM_NEURONS)  activation buffer read address.
act_rdata  in  DATA_WIDTH  activation data; valid one cycle after act_rd_en.
goodness_out  out  DATA_WIDTH  Q16.16 goodness; held until the next start.
goodness_valid  out  1  high from DONE until the next accepted start.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; accumulator and counters 0. A reset mid-operation aborts the pass immediately, with no done and goodness_out cleared.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: on start, latch N_eff = min(active_neurons, NUM_NEURONS), clear the accumulator, drop goodness_valid, then go to FETCH. If N_eff == 0, go straight to DONE.
- FETCH: registered act_rd_en=1 and act_addr=idx for idx = 0..N_eff-1, one address per cycle, no bubbles. After idx N_eff-1, go to DRAIN.
- DRAIN: exactly 3 cycles to flush the pipeline (read latency, square register, accumulate), then go to DONE.
- Pipeline: stage 1 registers act_rdata under a delayed valid. Stage 2 computes sq = (a*a)>>>FRAC_BITS as a 64-bit product, saturated to 0x7FFFFFFF, then registered. Stage 3 adds acc += sq, saturating at 2^ACC_WIDTH-1.
- DONE, one cycle: goodness_out = acc > 0x7FFFFFFF ? 0x7FFFFFFF : acc[31:0]. done=1, goodness_valid=1, then return to IDLE.
- Timing: with start sampled at the edge ending cycle t0, FETCH occupies t0+1..t0+N and done is high in cycle t0+N+4. For N=0, done is high in t0+1.
- Sign: negative activations square to positive values. goodness_out is never negative.
- start while busy: ignored, with no effect on the running pass.
- start in the same cycle as done (the DONE state): ignored. It must be re-asserted in IDLE.
- Counter wrap: idx must not wrap when N_eff == NUM_NEURONS, so it is sized with one extra bit.
- act_rd_en is low in every state except FETCH. act_addr holds its last value when act_rd_en is low.

Decomposition:
- Shared package ff_pkg holds:
  - DATA_WIDTH, FRAC_BITS, Q_ONE=32'h0001_0000, Q_MAX=32'h7FFF_FFFF.
  - The state_t enum for this block.
  - A q_square_sat function, also reusable by the plasticity engine's q_mul family.
- One natural sub-module, q16_square_sat: a registered saturating square that forms pipeline stage 2. Everything else stays in goodness_accumulator.

Test Plan:
- N=4, acts {0x00010000, 0x00020000, 0x00008000, 0xFFFF0000}, i.e. {1.0, 2.0, 0.5, -1.0} -> goodness_out=0x00064000 (6.25). done in cycle t0+8. Addresses 0,1,2,3 in consecutive cycles.
- N=256, all acts 0x00100000 (16.0) -> sum 65536.0 overflows -> goodness_out=0x7FFFFFFF, goodness_valid=1.
- N=1, act 0x7FFFFFFF -> square saturates to 0x7FFFFFFF -> goodness_out=0x7FFFFFFF. N=1, act 0 -> 0x00000000.
- N=0 -> done in t0+1, goodness_out=0, act_rd_en never asserted. active_neurons=300 -> clamped, exactly 256 reads issued.
- Second start pulse during FETCH of an N=8 pass -> ignored; exactly 8 reads issued and one done pulse.
- rst asserted at the third FETCH cycle -> next cycle: busy=0, act_rd_en=0, goodness_out=0, no done. A fresh N=2 pass {1.0, 1.0} then gives 0x00020000.
